// File: rtl/ksa_if.sv
// S-memory port and en/rdy handshake shared by the RC4 stages.
// The slave side is the KSA block; the master side is the controller and memory.
interface ksa_if #(
  parameter int unsigned KEY_BYTES = 3
) ();
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  modport master (output en, key, rddata, input rdy, addr, wrdata, wren);
  modport slave  (input en, key, rddata, output rdy, addr, wrdata, wren);
endinterface

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the shared 256x8 S memory in place using the key.
// Optional feature: define KSA_SKIP_SELF_SWAP_EN to skip the swap writes when j==i.
module ksa #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic  clk,
  input  logic  rst,
  ksa_if.slave  bus
);
  localparam int unsigned KEY_W = 8 * KEY_BYTES;
  localparam int unsigned K_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(KEY_BYTES - 1);

  typedef enum logic [2:0] {IDLE, RD_I, CALC_J, RD_J, WR_I, WR_J} state_t;

  state_t           state_q, state_d;
  logic [7:0]       i_q, i_d, j_q, j_d, si_q, si_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             rdy_q, rdy_d, wren_q, wren_d;
  logic [7:0]       addr_q, addr_d, wrd_q, wrd_d;
  logic             wr_rd_q, wr_rd_d;
  logic [7:0]       key_bytes [KEY_BYTES];
  logic [7:0]       key_byte;
  logic             skip;
  logic             advance;

  // Key byte 0 is the most significant byte of the captured key.
  always_comb begin
    for (int b = 0; b < KEY_BYTES; b++) begin
      key_bytes[b] = key_q[KEY_W-1-8*b -: 8];
    end
  end
  assign key_byte = key_bytes[k_q];

`ifdef KSA_SKIP_SELF_SWAP_EN
  assign skip = (j_q == i_q);
`else
  assign skip = 1'b0;
`endif

  // S[j] is only valid during WR_I, one cycle after its read, so that write
  // takes the memory read data straight through; every other write uses a register.
  assign bus.rdy    = rdy_q;
  assign bus.wren   = wren_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wr_rd_q ? bus.rddata : wrd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= '0;
      si_q    <= 8'd0;
      key_q   <= '0;
      rdy_q   <= 1'b1;
      wren_q  <= 1'b0;
      addr_q  <= 8'd0;
      wrd_q   <= 8'd0;
      wr_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      key_q   <= key_d;
      rdy_q   <= rdy_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wrd_q   <= wrd_d;
      wr_rd_q <= wr_rd_d;
    end
  end

  // Next state and datapath, then the registered outputs for the state being entered.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    key_d   = key_q;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          key_d   = bus.key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          state_d = RD_I;
        end
      end
      RD_I:   state_d = CALC_J;
      CALC_J: begin
        si_d    = bus.rddata;
        j_d     = j_q + bus.rddata + key_byte;
        state_d = RD_J;
      end
      RD_J: begin
        if (skip) advance = 1'b1;
        else      state_d = WR_I;
      end
      WR_I:    state_d = WR_J;
      WR_J:    advance = 1'b1;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      i_d     = i_q + 8'd1;
      k_d     = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
      state_d = (i_q == 8'hFF) ? IDLE : RD_I;
    end

    rdy_d   = 1'b0;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wrd_d   = 8'd0;
    wr_rd_d = 1'b0;
    case (state_d)
      IDLE:   rdy_d  = 1'b1;
      RD_I:   addr_d = i_d;
      CALC_J: addr_d = addr_q;
      RD_J:   addr_d = j_d;
      WR_I: begin
        addr_d  = i_d;
        wren_d  = 1'b1;
        wr_rd_d = 1'b1;
      end
      WR_J: begin
        addr_d = j_d;
        wrd_d  = si_d;
        wren_d = 1'b1;
      end
      default: rdy_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: a software RC4 KSA model predicts every memory write,
// the busy length and the final S contents.
module tb_ksa;
  localparam int unsigned KEY_BYTES = 3;
`ifdef KSA_SKIP_SELF_SWAP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int OFF1 = SKIP ? 0 : 2;
  localparam int OFF2 = SKIP ? 0 : 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ksa_if #(.KEY_BYTES(KEY_BYTES)) bus ();
  ksa #(.KEY_BYTES(KEY_BYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem   [256];
  logic [7:0] ref_s [256];
  bit         load_id;
  wr_t        exp_q [$];
  wr_t        exp_wr;
  int         exp_busy, self_swaps;
  int         n_chk = 0, n_pass = 0;
  logic [7:0] cyc_addr [1:5];
  logic       cyc_wren [1:5];
  logic [7:0] cyc_wrd  [1:5];

  // Single-port S memory: 1-cycle read latency, write at the end of the wren cycle.
  always @(posedge clk) begin
    if (load_id) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= mem[bus.addr];
  end

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Every write the DUT issues must be the next one the model predicted.
  always @(negedge clk) begin
    if (!rst && bus.wren) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(bus.addr), -1);
      end else begin
        exp_wr = exp_q.pop_front();
        chk("write_addr", int'(bus.addr), int'(exp_wr.a));
        chk("write_data", int'(bus.wrdata), int'(exp_wr.d));
      end
    end
  end

  // Plain RC4 KSA on ref_s; queues the expected write pairs for one run.
  task automatic model_run(input logic [23:0] k);
    int j, ss;
    logic [7:0] kb, t;
    j  = 0;
    ss = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(k >> (8 * (2 - (i % 3))));
      j  = (j + int'(ref_s[i]) + int'(kb)) % 256;
      if (i == j) ss++;
      if (!(SKIP && i == j)) begin
        exp_q.push_back('{a: 8'(i), d: ref_s[j]});
        exp_q.push_back('{a: 8'(j), d: ref_s[i]});
      end
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
    self_swaps = ss;
    exp_busy   = SKIP ? 1280 - 2 * ss : 1280;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_identity();
    load_id = 1'b1;
    step();
    load_id = 1'b0;
    for (int a = 0; a < 256; a++) ref_s[a] = 8'(a);
  endtask

  // Counts rdy=0 cycles until idle, recording the first five cycles' outputs.
  task automatic wait_idle(output int busy);
    busy = 0;
    while (!bus.rdy && busy < 3000) begin
      busy++;
      if (busy <= 5) begin
        cyc_addr[busy] = bus.addr;
        cyc_wren[busy] = bus.wren;
        cyc_wrd[busy]  = bus.wrdata;
      end
      step();
    end
  endtask

  task automatic start(input logic [23:0] k);
    bus.key = k;
    bus.en  = 1'b1;
    step();
    bus.en  = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_s[a]) bad++;
    chk(name, bad, 0);
    chk({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic full_run(input logic [23:0] k, input string name);
    int busy, eb;
    load_identity();
    model_run(k);
    eb = exp_busy;
    start(k);
    wait_idle(busy);
    chk({name, "_busy"}, busy, eb);
    check_mem({name, "_mem_bad_bytes"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy, b1, b2, nw;
    logic [23:0] k, k2;
    rst     = 1'b1;
    load_id = 1'b0;
    bus.en  = 1'b0;
    bus.key = '0;
    step();
    step();
    chk("reset_rdy", int'(bus.rdy), 1);
    chk("reset_wren", int'(bus.wren), 0);
    chk("reset_addr", int'(bus.addr), 0);
    chk("reset_wrdata", int'(bus.wrdata), 0);
    rst = 1'b0;
    step();

    // Scenario 1 and 5: key 00033C, model pinned by hand, first iteration cycle by cycle.
    load_identity();
    model_run(24'h00033C);
    chk("pin_33c_it1_addr_i", int'(exp_q[OFF1].a), 1);
    chk("pin_33c_it1_data_i", int'(exp_q[OFF1].d), 4);
    chk("pin_33c_it1_addr_j", int'(exp_q[OFF1+1].a), 4);
    chk("pin_33c_it1_data_j", int'(exp_q[OFF1+1].d), 1);
    chk("pin_33c_it2_addr_j", int'(exp_q[OFF1+3].a), 8'h42);
    b1 = exp_busy;
    start(24'h00033C);
    wait_idle(busy);
    chk("s1_busy", busy, b1);
    chk("s1_rdy_after", int'(bus.rdy), 1);
    check_mem("s1_mem_bad_bytes");
    chk("s5_c1_addr", int'(cyc_addr[1]), 0);
    chk("s5_c1_wren", int'(cyc_wren[1]), 0);
    chk("s5_c3_addr", int'(cyc_addr[3]), 0);
    chk("s5_c4_addr", int'(cyc_addr[4]), SKIP ? 1 : 0);
    chk("s5_c4_wrdata", int'(cyc_wrd[4]), 0);
    chk("s5_c4_wren", int'(cyc_wren[4]), SKIP ? 0 : 1);
    chk("s5_c5_wren", int'(cyc_wren[5]), SKIP ? 0 : 1);

    // Scenario 2 / 6: all-zero key, self-swaps on iterations 0 and 1.
    load_identity();
    model_run(24'h000000);
    chk("pin_zero_it2_addr_i", int'(exp_q[OFF2].a), 2);
    chk("pin_zero_it2_data_i", int'(exp_q[OFF2].d), 3);
    chk("pin_zero_it2_addr_j", int'(exp_q[OFF2+1].a), 3);
    chk("pin_zero_it2_data_j", int'(exp_q[OFF2+1].d), 2);
    chk("pin_zero_selfswaps_ge2", int'(self_swaps >= 2), 1);
    b1 = exp_busy;
    start(24'h000000);
    wait_idle(busy);
    chk("s2_busy", busy, b1);
    check_mem("s2_mem_bad_bytes");

    // Scenario 3: en held high; key changes mid-run and is only taken at the restart.
    load_identity();
    k  = 24'($urandom);
    k2 = ~k;
    model_run(k);
    b1 = exp_busy;
    model_run(k2);
    b2 = exp_busy;
    bus.key = k;
    bus.en  = 1'b1;
    step();
    bus.key = k2;
    wait_idle(busy);
    chk("s3_run1_busy", busy, b1);
    chk("s3_idle_rdy", int'(bus.rdy), 1);
    step();
    chk("s3_restart_rdy", int'(bus.rdy), 0);
    bus.en = 1'b0;
    wait_idle(busy);
    chk("s3_run2_busy", busy, b2);
    check_mem("s3_mem_bad_bytes");

    // Scenario 4: reset at busy cycle 600 aborts the run; no further writes.
    load_identity();
    model_run(24'h00033C);
    start(24'h00033C);
    for (int c = 1; c < 600; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s4_rdy_after_rst", int'(bus.rdy), 1);
    chk("s4_wren_after_rst", int'(bus.wren), 0);
    exp_q.delete();
    nw = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.wren) nw++;
      step();
    end
    chk("s4_writes_after_rst", nw, 0);
    full_run(24'h00033C, "s4_rerun");

    // Random keys from identity.
    for (int r = 0; r < 3; r++) full_run(24'($urandom), "rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
